// File: rtl/alu_seq.sv
// alu_seq: operand sequencer and writeback stage around an external
// combinational 8-bit ALU.
//
// Accepts one instruction at a time over a valid/ready handshake. Operands are
// read from an internal 8x8-bit register file (r0 hardwired to zero) and
// presented to the ALU from registers. The ALU result and flags are captured
// one cycle later into the register file and the flag register.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   instr_valid/ready    instruction handshake (ready high only in IDLE)
//   instr_op             ALU select code, passed through unmodified
//   instr_rd/rs1/rs2     destination and source register indices
//   instr_imm_en/imm     use immediate instead of rs2 for y
//   alu_x/alu_y/alu_sel  registered ALU operands
//   alu_out + flags      ALU result and {zero, carry, overflow, negative}
//   wb_valid/rd/data     one-cycle writeback pulse; rd/data hold until next wb
//   flags                {negative, overflow, carry, zero} of last writeback
//   retired              count of completed instructions (wraps)
//   dbg_addr/dbg_data    combinational register-file debug read
module alu_seq #(
    parameter int unsigned NREG  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_op,
    input  logic [2:0]       instr_rd,
    input  logic [2:0]       instr_rs1,
    input  logic [2:0]       instr_rs2,
    input  logic             instr_imm_en,
    input  logic [7:0]       instr_imm,
    output logic [7:0]       alu_x,
    output logic [7:0]       alu_y,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_negative,
    output logic             wb_valid,
    output logic [2:0]       wb_rd,
    output logic [7:0]       wb_data,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] retired,
    input  logic [2:0]       dbg_addr,
    output logic [7:0]       dbg_data
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t             state_q;
    logic               ready_q;
    logic [7:0]         rf_q [NREG];
    logic [2:0]         rd_q;
    logic [7:0]         alu_x_q;
    logic [7:0]         alu_y_q;
    logic [3:0]         alu_sel_q;
    logic               wb_valid_q;
    logic [2:0]         wb_rd_q;
    logic [7:0]         wb_data_q;
    logic [3:0]         flags_q;
    logic [CNT_W-1:0]   retired_q;

    logic [7:0]         rs1_val;
    logic [7:0]         rs2_val;

    // r0 reads as zero regardless of storage contents.
    always_comb begin
        rs1_val  = (instr_rs1 == 3'd0) ? '0 : rf_q[instr_rs1];
        rs2_val  = (instr_rs2 == 3'd0) ? '0 : rf_q[instr_rs2];
        dbg_data = (dbg_addr  == 3'd0) ? '0 : rf_q[dbg_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            rd_q       <= '0;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            alu_sel_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            flags_q    <= '0;
            retired_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    wb_valid_q <= 1'b0;
                    if (instr_valid) begin
                        alu_x_q   <= rs1_val;
                        alu_y_q   <= instr_imm_en ? instr_imm : rs2_val;
                        alu_sel_q <= instr_op;
                        rd_q      <= instr_rd;
                        ready_q   <= 1'b0;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    // Writes to r0 still report a writeback; only storage is skipped.
                    if (rd_q != 3'd0) begin
                        rf_q[rd_q] <= alu_out;
                    end
                    flags_q    <= {alu_negative, alu_overflow, alu_carry, alu_zero};
                    wb_valid_q <= 1'b1;
                    wb_rd_q    <= rd_q;
                    wb_data_q  <= alu_out;
                    retired_q  <= retired_q + CNT_W'(1);
                    ready_q    <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign alu_x       = alu_x_q;
    assign alu_y       = alu_y_q;
    assign alu_sel     = alu_sel_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign flags       = flags_q;
    assign retired     = retired_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Operand sequencer and writeback stage wrapped around the combinational 8-bit ALU. It accepts one register-to-register or register-to-immediate instruction at a time over a valid/ready handshake and reads operands from an internal 8×8-bit register file. It drives the ALU's `x`/`y`/`sel` from registers, then captures the ALU result and flags one cycle later into the register file and a flag register. It sits directly upstream of the ALU, which feeds it, and directly downstream of it, consuming what it produces.

## Interface
- `NREG`, 8: register-file depth; index width is 3 bits; only 8 is supported.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `instr_valid` in 1: instruction present.
- `instr_ready` out 1: block can accept; high only in IDLE.
- `instr_op` in 4: ALU select code, passed unmodified (0 Add, 1 Sub, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 XNOR, 7 NOT, 8 NAND, 9 NOR, 10 SLT, 11 SLL, 12 SLR, 13 ROL, 14 ROR).
- `instr_rd` in 3: destination register.
- `instr_rs1` in 3: source register for `x`.
- `instr_rs2` in 3: source register for `y`; ignored when `instr_imm_en`=1.
- `instr_imm_en` in 1: `y` taken from `instr_imm`.
- `instr_imm` in 8: immediate operand.
- `alu_x` out 8, `alu_y` out 8, `alu_sel` out 4: registered ALU operands.
- `alu_out` in 8, `alu_zero` in 1, `alu_carry` in 1, `alu_overflow` in 1, `alu_negative` in 1: ALU result and flags.
- `wb_valid` out 1: one-cycle writeback pulse.
- `wb_rd` out 3: register written by the current writeback.
- `wb_data` out 8: data written by the current writeback.
- `flags` out 4: `{negative, overflow, carry, zero}` from the last writeback.
- `retired` out CNT_W: count of completed instructions.
- `dbg_addr` in 3: register-file read address for debug.
- `dbg_data` out 8: combinational read of `rf[dbg_addr]`; r0 reads 0.

## Operation
- States:
  - IDLE: `instr_ready`=1.
  - EXEC: `instr_ready`=0.
- IDLE → EXEC on `instr_valid && instr_ready`. At that edge:
  - `alu_x` ← `rf[rs1]`;
  - `alu_y` ← `instr_imm_en ? instr_imm : rf[rs2]`;
  - `alu_sel` ← `instr_op`;
  - `rd` is latched internally.
- EXEC → IDLE unconditionally on the next edge. At that edge:
  - `rf[rd]` ← `alu_out`, except when `rd`=0;
  - `flags` ← ALU flags;
  - `wb_valid` ← 1, `wb_rd` ← rd, `wb_data` ← `alu_out`;
  - `retired` += 1.
- `wb_valid` returns to 0 on the following edge. `wb_rd`/`wb_data` hold their values until the next writeback.
- r0 is hardwired to zero. A write to r0 still pulses `wb_valid`, presents `alu_out` on `wb_data`, updates `flags` and increments `retired`; `rf[0]` stays 0.
- Reads of r0 as rs1 or rs2 return 0.
- `alu_x`/`alu_y`/`alu_sel` hold their values in IDLE. They change only at acceptance.
- Codes outside 0..14 are passed through. The ALU returns 0 with zero=1, and that result is written normally.
- `retired` wraps 0xFFFF → 0x0000 without a flag.
- Instruction inputs are sampled only at the acceptance edge. `instr_valid` while `instr_ready`=0 is ignored; the source holds it.
- No hazards: the earliest next acceptance is the edge after writeback, so it reads the updated register.

## Timing
- Reset (asynchronous assert, synchronous release on the first edge after deassert):
  - state IDLE;
  - all `rf` = 0;
  - `alu_x`/`alu_y`/`alu_sel` = 0;
  - `wb_valid`=0, `wb_rd`=0, `wb_data`=0;
  - `flags`=0, `retired`=0;
  - `instr_ready`=1 immediately.
- Accept at edge T0. ALU is evaluated during cycle T0–T1. Writeback is at T1. `wb_valid` is high during T1–T2. `rf` is updated and visible on `dbg_data` after T1.
- Latency is 2 edges. Throughput is one instruction per 2 cycles. `instr_ready` pattern with `instr_valid` held high: 1,0,1,0….
- Reset asserted in EXEC: the instruction is dropped. No write, no `wb_valid`, `retired` not incremented.
- The ALU path is combinational between registered `alu_*` outputs and the capture registers; the full ALU delay must fit in one cycle.

## Test plan
- Reset, then OR rd=1 rs1=0 imm 0x7F → `wb_valid` 1 cycle, `wb_data`=0x7F, `flags`=0000, `dbg r1`=0x7F, `retired`=1.
- Add rd=2 rs1=1 imm 0x01 → `wb_data`=0x80, `flags`=`{N=1,V=1,C=0,Z=0}`.
- Sub rd=3 rs1=0 imm 0x01 → `wb_data`=0xFF, C=1, N=1, V=0, Z=0. Then Sub rd=4 rs1=3 rs2=3 → 0x00, Z=1.
- Add rd=0 rs1=0 imm 0x05 → `wb_valid`=1, `wb_data`=0x05, `wb_rd`=0, `dbg r0`=0x00.
- `instr_valid` held high for 4 instructions → `instr_ready` 1,0,1,0,…, exactly 4 `wb_valid` pulses, 8 cycles total, `retired`+=4.
- Assert `rst_n` low during EXEC of Add rd=5 → no `wb_valid`, `dbg r5`=0, all outputs at reset values. Separately, 65536 instructions → `retired` wraps to 0.
